// File: rtl/led_cube_pkg.sv
// rtl/led_cube_pkg.sv - shared types, constants and index helpers for the LED cube move scheduler
package led_cube_pkg;

   localparam int N_LED   = 64;
   localparam int GRB_W   = 24;
   localparam int COORD_W = 2;
   localparam int IDX_W   = 3 * COORD_W;
   localparam int FRAME_W = N_LED * GRB_W;

   localparam logic [GRB_W-1:0] GRB_BLACK = 24'h000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      CLEAR = 2'd2,
      WRITE = 2'd3
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0]   number;
      logic [COORD_W-1:0] dx;
      logic [COORD_W-1:0] dy;
      logic [COORD_W-1:0] dz;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // Each axis adds in its own 2-bit field, so overflow wraps within the axis.
   function automatic logic [IDX_W-1:0] dest_index(input cmd_t c);
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] z;
      x = c.number[1:0] + c.dx;
      y = c.number[3:2] + c.dy;
      z = c.number[5:4] + c.dz;
      return {z, y, x};
   endfunction

   function automatic logic axis_overflow(input cmd_t c);
      logic [COORD_W:0] sx;
      logic [COORD_W:0] sy;
      logic [COORD_W:0] sz;
      sx = {1'b0, c.number[1:0]} + {1'b0, c.dx};
      sy = {1'b0, c.number[3:2]} + {1'b0, c.dy};
      sz = {1'b0, c.number[5:4]} + {1'b0, c.dz};
      return sx[COORD_W] | sy[COORD_W] | sz[COORD_W];
   endfunction

endpackage

// File: rtl/led_move_scheduler_if.sv
// rtl/led_move_scheduler_if.sv - move-command handshake between pattern logic and the scheduler
interface led_move_scheduler_if;
   import led_cube_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [IDX_W-1:0]   cmd_number;
   logic [COORD_W-1:0] cmd_dx;
   logic [COORD_W-1:0] cmd_dy;
   logic [COORD_W-1:0] cmd_dz;

   modport master (
      output cmd_valid, cmd_number, cmd_dx, cmd_dy, cmd_dz,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_number, cmd_dx, cmd_dy, cmd_dz,
      output cmd_ready
   );

endinterface

// File: rtl/led_cmd_fifo.sv
// rtl/led_cmd_fifo.sv - first-word-fall-through command FIFO, power-of-two depth
module led_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/led_move_scheduler.sv
// rtl/led_move_scheduler.sv - LED cube frame store applying queued pixel moves (read/clear/write)
// Optional LED_MOVE_CLIP_EN: drop moves whose axis sum leaves the cube instead of wrapping.
module led_move_scheduler
   import led_cube_pkg::*;
#(
   parameter int CMD_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [FRAME_W-1:0] frame_in,
   led_move_scheduler_if.slave cmd,
   output logic [FRAME_W-1:0] frame_out,
   output logic               busy,
   output logic               done,
   output logic               drop_err
);

   state_e                        state_q, state_d;
   logic [N_LED-1:0][GRB_W-1:0]   frame_q, frame_d;
   cmd_t                          cmd_q, cmd_d;
   logic [GRB_W-1:0]              hold_q, hold_d;
   logic [IDX_W-1:0]              dst_q, dst_d;
   logic                          done_q, done_d;
   cmd_t                          push_cmd;
   cmd_t                          fifo_data;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic                          pop;

   assign push_cmd = '{number: cmd.cmd_number, dx: cmd.cmd_dx, dy: cmd.cmd_dy, dz: cmd.cmd_dz};

   led_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .W     (CMD_W)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd.cmd_valid),
      .data_i  (push_cmd),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cmd.cmd_ready = ~fifo_full;
   assign frame_out     = frame_q;
   assign busy          = (state_q != IDLE) | ~fifo_empty;
   assign done          = done_q;

`ifdef LED_MOVE_CLIP_EN
   logic drop_q, drop_d;
   assign drop_err = drop_q;
`else
   assign drop_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cmd_d   = cmd_q;
      hold_d  = hold_q;
      dst_d   = dst_q;
      done_d  = 1'b0;
      pop     = 1'b0;
`ifdef LED_MOVE_CLIP_EN
      drop_d  = 1'b0;
`endif
      case (state_q)
         // A load wins over popping; the queued command waits one cycle.
         IDLE: begin
            if (load) begin
               frame_d = frame_in;
            end else if (!fifo_empty) begin
               pop     = 1'b1;
               cmd_d   = fifo_data;
               state_d = READ;
            end
         end
         READ: begin
            hold_d  = frame_q[cmd_q.number];
            dst_d   = dest_index(cmd_q);
            state_d = CLEAR;
`ifdef LED_MOVE_CLIP_EN
            if (axis_overflow(cmd_q)) begin
               drop_d  = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         CLEAR: begin
            frame_d[cmd_q.number] = GRB_BLACK;
            state_d               = WRITE;
         end
         // Writing after the clear means a zero-offset move restores the pixel.
         WRITE: begin
            frame_d[dst_q] = hold_q;
            done_d         = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         frame_q <= '0;
         cmd_q   <= '0;
         hold_q  <= GRB_BLACK;
         dst_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cmd_q   <= cmd_d;
         hold_q  <= hold_d;
         dst_q   <= dst_d;
         done_q  <= done_d;
      end
   end

`ifdef LED_MOVE_CLIP_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= drop_d;
      end
   end
`endif

endmodule

// File: tb/tb_led_move_scheduler.sv
// tb/tb_led_move_scheduler.sv - self-checking bench for led_move_scheduler
module tb_led_move_scheduler;
   import led_cube_pkg::*;

`ifdef LED_MOVE_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               load = 1'b0;
   logic [FRAME_W-1:0] frame_in = '0;
   logic [FRAME_W-1:0] frame_out;
   logic               busy;
   logic               done;
   logic               drop_err;

   led_move_scheduler_if cmd_if ();

   led_move_scheduler #(.CMD_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .frame_in  (frame_in),
      .cmd       (cmd_if.slave),
      .frame_out (frame_out),
      .busy      (busy),
      .done      (done),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [23:0] mdl [N_LED];

   typedef struct {
      logic [5:0]  num;
      logic [1:0]  dx;
      logic [1:0]  dy;
      logic [1:0]  dz;
      logic [23:0] color;
      logic [5:0]  exp_dst;
      bit          exp_ovf;
   } vec_t;

   vec_t vecs [6];
   cmd_t bb [5];
   cmd_t q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [FRAME_W-1:0] model_flat();
      logic [FRAME_W-1:0] f;
      for (int i = 0; i < N_LED; i++) f[i*24 +: 24] = mdl[i];
      return f;
   endfunction

   task automatic chk_frame(input string name);
      logic [FRAME_W-1:0] exp;
      exp = model_flat();
      checks++;
      if (frame_out !== exp) begin
         errors++;
         for (int i = 0; i < N_LED; i++) begin
            if (frame_out[i*24 +: 24] !== exp[i*24 +: 24]) begin
               $display("FAIL %s: pixel %0d got %06h expected %06h", name, i,
                        frame_out[i*24 +: 24], exp[i*24 +: 24]);
               break;
            end
         end
      end
   endtask

   // Reference move from cube geometry: decode coordinates, add per axis, re-encode.
   task automatic model_move(input cmd_t c, output bit dropped);
      int n, x, y, z, dst;
      logic [23:0] col;
      n = int'(c.number);
      x = n % 4;
      y = (n / 4) % 4;
      z = n / 16;
      dropped = CLIP && ((x + int'(c.dx) > 3) || (y + int'(c.dy) > 3) || (z + int'(c.dz) > 3));
      dst = ((x + int'(c.dx)) % 4) + 4 * ((y + int'(c.dy)) % 4) + 16 * ((z + int'(c.dz)) % 4);
      if (!dropped) begin
         col = mdl[n];
         mdl[n] = 24'h0;
         mdl[dst] = col;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk(name, busy, 0);
   endtask

   task automatic do_load();
      frame_in = model_flat();
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic set_cmd(input cmd_t c, input bit v);
      cmd_if.cmd_valid  = v;
      cmd_if.cmd_number = c.number;
      cmd_if.cmd_dx     = c.dx;
      cmd_if.cmd_dy     = c.dy;
      cmd_if.cmd_dz     = c.dz;
   endtask

   function automatic cmd_t mk(input int num, input int dx, input int dy, input int dz);
      cmd_t c;
      c.number = 6'(num);
      c.dx = 2'(dx);
      c.dy = 2'(dy);
      c.dz = 2'(dz);
      return c;
   endfunction

   initial begin
      bit   dropped, acc, saw_full, drop;
      int   dones, k, n, sent;
      cmd_t c;

      vecs[0] = '{6'd0,  2'd1, 2'd0, 2'd0, 24'hFF0000, 6'd1,  1'b0};
      vecs[1] = '{6'd63, 2'd1, 2'd1, 2'd1, 24'h00FF00, 6'd0,  1'b1};
      vecs[2] = '{6'd21, 2'd0, 2'd0, 2'd0, 24'h123456, 6'd21, 1'b0};
      vecs[3] = '{6'd5,  2'd3, 2'd0, 2'd2, 24'hAABBCC, 6'd36, 1'b1};
      vecs[4] = '{6'd0,  2'd3, 2'd3, 2'd3, 24'h0F0F0F, 6'd63, 1'b0};
      vecs[5] = '{6'd42, 2'd1, 2'd0, 2'd0, 24'h000000, 6'd43, 1'b0};
      bb[0] = mk(0, 1, 0, 0);
      bb[1] = mk(1, 0, 1, 0);
      bb[2] = mk(5, 0, 0, 1);
      bb[3] = mk(21, 1, 0, 0);
      bb[4] = mk(22, 1, 0, 0);

      // Reset, with load held high to show reset dominates.
      set_cmd(mk(0, 0, 0, 0), 1'b0);
      frame_in = {FRAME_W{1'b1}};
      load = 1'b1;
      repeat (3) tick();
      load = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < N_LED; i++) mdl[i] = 24'h0;
      chk_frame("reset frame");
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset drop_err", drop_err, 0);
      chk("reset cmd_ready", cmd_if.cmd_ready, 1);

      // Table vectors with exact cycle latency.
      foreach (vecs[v]) begin
         wait_idle("vec idle");
         for (int i = 0; i < N_LED; i++) mdl[i] = 24'h0;
         mdl[vecs[v].num] = vecs[v].color;
         if (vecs[v].exp_dst != vecs[v].num) mdl[vecs[v].exp_dst] = 24'hABCDEF;
         do_load();
         chk_frame("vec load");
         drop = CLIP && vecs[v].exp_ovf;
         set_cmd(mk(vecs[v].num, vecs[v].dx, vecs[v].dy, vecs[v].dz), 1'b1);
         tick();
         cmd_if.cmd_valid = 1'b0;
         for (int i = 1; i <= 5; i++) begin
            tick();
            if (i < 4) chk("vec early done", done, 0);
            if (i == 2) chk("vec drop_err", drop_err, drop);
            if (i == 3 && !drop) chk("vec src cleared", frame_out[vecs[v].num*24 +: 24], 0);
            if (i == 4) begin
               chk("vec done", done, !drop);
               if (!drop) begin
                  mdl[vecs[v].num] = 24'h0;
                  mdl[vecs[v].exp_dst] = vecs[v].color;
               end
               chk_frame("vec result");
            end
            if (i == 5) begin
               chk("vec done falls", done, 0);
               chk("vec busy falls", busy, 0);
            end
         end
      end

      // Five back-to-back commands chaining one pixel through the cube.
      wait_idle("bb idle");
      for (int i = 0; i < N_LED; i++) mdl[i] = 24'h0;
      mdl[0] = 24'hC0FFEE;
      do_load();
      k = 0; n = 0; dones = 0; saw_full = 0;
      set_cmd(bb[0], 1'b1);
      while (n < 100 && (k < 5 || busy)) begin
         if (!cmd_if.cmd_ready) saw_full = 1;
         acc = cmd_if.cmd_valid && cmd_if.cmd_ready;
         tick();
         n++;
         if (acc) begin
            k++;
            if (k < 5) set_cmd(bb[k], 1'b1);
            else cmd_if.cmd_valid = 1'b0;
         end
         if (done) begin
            if (dones < 5) model_move(bb[dones], dropped);
            dones++;
            chk_frame("bb step");
            if (dones == 5) chk("bb busy at last done", busy, 0);
         end
      end
      cmd_if.cmd_valid = 1'b0;
      chk("bb saw full", saw_full, 1);
      chk("bb dones", dones, 5);
      chk("bb busy end", busy, 0);

      // load during WRITE is ignored.
      wait_idle("lw idle");
      for (int i = 0; i < N_LED; i++) mdl[i] = 24'h0;
      mdl[7] = 24'h0000FF;
      do_load();
      set_cmd(mk(7, 0, 0, 1), 1'b1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      repeat (3) tick();
      frame_in = {FRAME_W{1'b1}};
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("lw done", done, 1);
      model_move(mk(7, 0, 0, 1), dropped);
      chk_frame("lw frame");

      // load in IDLE with a queued command defers the pop by one cycle.
      wait_idle("li idle");
      set_cmd(mk(9, 1, 0, 0), 1'b1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int i = 0; i < N_LED; i++) mdl[i] = 24'($urandom);
      mdl[9] = 24'h999999;
      frame_in = model_flat();
      load = 1'b1;
      tick();
      load = 1'b0;
      chk_frame("li loaded");
      chk("li busy", busy, 1);
      for (int i = 2; i <= 5; i++) begin
         tick();
         if (i < 5) chk("li deferred done", done, 0);
      end
      chk("li done", done, 1);
      model_move(mk(9, 1, 0, 0), dropped);
      chk_frame("li frame");

      // Reset while a command is in CLEAR and another is queued.
      wait_idle("rc idle");
      for (int i = 0; i < N_LED; i++) mdl[i] = 24'h5A5A5A;
      do_load();
      set_cmd(mk(3, 1, 0, 0), 1'b1);
      tick();
      set_cmd(mk(12, 0, 1, 0), 1'b1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < N_LED; i++) mdl[i] = 24'h0;
      chk_frame("rc frame");
      chk("rc busy", busy, 0);
      chk("rc done", done, 0);
      chk("rc ready", cmd_if.cmd_ready, 1);
      repeat (5) begin
         tick();
         chk("rc no done", done, 0);
      end
      chk("rc busy later", busy, 0);

      // Randomized traffic against the scoreboard model.
      for (int i = 0; i < N_LED; i++) mdl[i] = 24'($urandom);
      do_load();
      sent = 0; n = 0;
      q.delete();
      set_cmd(mk($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      while (n < 3000 && (sent < 40 || q.size() != 0 || busy)) begin
         if (done || drop_err) begin
            if (q.size() == 0) begin
               chk("rnd spurious event", {done, drop_err}, 0);
            end else begin
               c = q.pop_front();
               model_move(c, dropped);
               chk("rnd event kind", {done, drop_err}, dropped ? 2'b01 : 2'b10);
               chk_frame("rnd frame");
            end
         end
         acc = cmd_if.cmd_valid && cmd_if.cmd_ready;
         if (acc) begin
            c = mk(cmd_if.cmd_number, cmd_if.cmd_dx, cmd_if.cmd_dy, cmd_if.cmd_dz);
            q.push_back(c);
            sent++;
         end
         tick();
         n++;
         if (!cmd_if.cmd_valid || acc) begin
            set_cmd(mk($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3)), (sent < 40) && ($urandom_range(0, 2) != 0));
         end
      end
      cmd_if.cmd_valid = 1'b0;
      chk("rnd all sent", sent, 40);
      chk("rnd queue drained", q.size(), 0);
      chk("rnd busy end", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
